lab3_multi_timer: RTL and testbench

Parametrised multi-channel interval timer, successor of the single-channel 16-bit-bus timer. It exposes NUM_CH independent down-counters behind one Avalon-MM slave with a 32-bit data bus. Each channel adds a clock prescaler, a live count read and one-shot or continuous mode. Per-channel and combined interrupts go to the Nios II interrupt controller.

---
 rtl/lab3_multi_timer_pkg.sv | 44 ++++
 rtl/lab3_timer_channel.sv | 165 ++++++++++++++++
 rtl/lab3_multi_timer.sv | 86 ++++++++
 tb/tb_lab3_multi_timer.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/lab3_multi_timer_pkg.sv
// Shared constants for the multi-channel interval timer: register offsets
// inside a channel window and bit positions of the STATUS/CONTROL fields.
`timescale 1ns/1ps
package lab3_multi_timer_pkg;

    // Register offsets within one channel (address[2:0])
    localparam logic [2:0] REG_STATUS   = 3'd0;
    localparam logic [2:0] REG_CONTROL  = 3'd1;
    localparam logic [2:0] REG_PERIOD   = 3'd2;
    localparam logic [2:0] REG_SNAP     = 3'd3;
    localparam logic [2:0] REG_PRESCALE = 3'd4;
    localparam logic [2:0] REG_COUNT    = 3'd5;

    // STATUS bits
    localparam int STAT_TO_BIT  = 0;
    localparam int STAT_RUN_BIT = 1;

    // CONTROL bits (START/STOP are write-only strobes)
    localparam int CTRL_ITO_BIT   = 0;
    localparam int CTRL_CONT_BIT  = 1;
    localparam int CTRL_START_BIT = 2;
    localparam int CTRL_STOP_BIT  = 3;

    // Per-channel decoded write strobes
    typedef struct packed {
        logic status;
        logic control;
        logic period;
        logic snap;
        logic prescale;
    } chan_wr_t;

    // Decode a channel-level write into one-hot register strobes
    function automatic chan_wr_t decode_write(input logic wr_en, input logic [2:0] reg_sel);
        chan_wr_t w;
        w.status   = wr_en && (reg_sel == REG_STATUS);
        w.control  = wr_en && (reg_sel == REG_CONTROL);
        w.period   = wr_en && (reg_sel == REG_PERIOD);
        w.snap     = wr_en && (reg_sel == REG_SNAP);
        w.prescale = wr_en && (reg_sel == REG_PRESCALE);
        return w;
    endfunction

endpackage

// File: rtl/lab3_timer_channel.sv
// One timer channel: prescaler, down-counter, PERIOD/PRESCALE/SNAP/CONTROL
// registers, TO/RUN flags and the channel interrupt.
`timescale 1ns/1ps
module lab3_timer_channel
    import lab3_multi_timer_pkg::*;
#(
    parameter int          CNT_W      = 32,
    parameter int          PRE_W      = 16,
    parameter int unsigned RST_PERIOD = 50_000_000 - 1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        wr_en,
    input  logic [2:0]  reg_sel,
    input  logic [31:0] writedata,
    output logic [31:0] rd_data,
    output logic        irq
);

    localparam logic [CNT_W-1:0] RST_VAL = CNT_W'(RST_PERIOD);

    logic [CNT_W-1:0] counter_reg,  counter_next;
    logic [CNT_W-1:0] period_reg,   period_next;
    logic [CNT_W-1:0] snap_reg,     snap_next;
    logic [PRE_W-1:0] prescale_reg, prescale_next;
    logic [PRE_W-1:0] presc_cnt_reg, presc_cnt_next;
    logic             to_reg,   to_next;
    logic             run_reg,  run_next;
    logic             ito_reg,  ito_next;
    logic             cont_reg, cont_next;
    logic             reload_pend_reg, reload_pend_next;

    chan_wr_t wr;
    logic     start;
    logic     stop;
    logic     tick;
    logic     timeout;

    assign wr      = decode_write(wr_en, reg_sel);
    assign start   = wr.control && writedata[CTRL_START_BIT];
    assign stop    = wr.control && writedata[CTRL_STOP_BIT];
    // A pending force-reload owns the cycle, so no tick is taken alongside it
    assign tick    = run_reg && (presc_cnt_reg == '0) && !reload_pend_reg;
    assign timeout = tick && (counter_reg == '0);

    // Next-state logic for all channel registers
    always_comb begin
        counter_next     = counter_reg;
        period_next      = period_reg;
        snap_next        = snap_reg;
        prescale_next    = prescale_reg;
        presc_cnt_next   = presc_cnt_reg;
        to_next          = to_reg;
        run_next         = run_reg;
        ito_next         = ito_reg;
        cont_next        = cont_reg;
        reload_pend_next = wr.period || wr.prescale;

        if (wr.control) begin
            ito_next  = writedata[CTRL_ITO_BIT];
            cont_next = writedata[CTRL_CONT_BIT];
        end
        if (wr.period) begin
            period_next = writedata[CNT_W-1:0];
        end
        if (wr.prescale) begin
            prescale_next = writedata[PRE_W-1:0];
        end
        // Capture uses the count from before this edge's update
        if (wr.snap) begin
            snap_next = counter_reg;
        end

        // Prescaler: reload on force-reload or a fresh START so the first
        // decrement lands PRESCALE+1 clocks after RUN sets
        if (reload_pend_reg) begin
            presc_cnt_next = prescale_reg;
        end else if (start && !stop && !run_reg) begin
            presc_cnt_next = prescale_reg;
        end else if (run_reg) begin
            if (presc_cnt_reg == '0) begin
                presc_cnt_next = prescale_reg;
            end else begin
                presc_cnt_next = presc_cnt_reg - PRE_W'(1);
            end
        end

        // Counter
        if (reload_pend_reg) begin
            counter_next = period_reg;
        end else if (tick) begin
            if (counter_reg == '0) begin
                counter_next = period_reg;
            end else begin
                counter_next = counter_reg - CNT_W'(1);
            end
        end

        // RUN: reload and STOP beat START; START on a running channel is a no-op
        if (reload_pend_reg || stop) begin
            run_next = 1'b0;
        end else if (start && !run_reg) begin
            run_next = 1'b1;
        end else if (timeout && !cont_reg) begin
            run_next = 1'b0;
        end

        // TO: a timeout in the same cycle as a STATUS write keeps TO set
        if (timeout) begin
            to_next = 1'b1;
        end else if (wr.status) begin
            to_next = 1'b0;
        end
    end

    // Channel state registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            counter_reg     <= RST_VAL;
            period_reg      <= RST_VAL;
            snap_reg        <= '0;
            prescale_reg    <= '0;
            presc_cnt_reg   <= '0;
            to_reg          <= 1'b0;
            run_reg         <= 1'b0;
            ito_reg         <= 1'b0;
            cont_reg        <= 1'b0;
            reload_pend_reg <= 1'b0;
        end else begin
            counter_reg     <= counter_next;
            period_reg      <= period_next;
            snap_reg        <= snap_next;
            prescale_reg    <= prescale_next;
            presc_cnt_reg   <= presc_cnt_next;
            to_reg          <= to_next;
            run_reg         <= run_next;
            ito_reg         <= ito_next;
            cont_reg        <= cont_next;
            reload_pend_reg <= reload_pend_next;
        end
    end

    // Register read value for the selected offset, zero-extended
    always_comb begin
        rd_data = '0;
        case (reg_sel)
            REG_STATUS: begin
                rd_data[STAT_TO_BIT]  = to_reg;
                rd_data[STAT_RUN_BIT] = run_reg;
            end
            REG_CONTROL: begin
                rd_data[CTRL_ITO_BIT]  = ito_reg;
                rd_data[CTRL_CONT_BIT] = cont_reg;
            end
            REG_PERIOD:   rd_data = 32'(period_reg);
            REG_SNAP:     rd_data = 32'(snap_reg);
            REG_PRESCALE: rd_data = 32'(prescale_reg);
            REG_COUNT:    rd_data = 32'(counter_reg);
            default:      rd_data = '0;
        endcase
    end

    assign irq = to_reg && ito_reg;

endmodule

// File: rtl/lab3_multi_timer.sv
// Multi-channel interval timer behind an Avalon-MM slave: address decode,
// NUM_CH channel instances, registered read mux and the combined interrupt.
`timescale 1ns/1ps
module lab3_multi_timer
    import lab3_multi_timer_pkg::*;
#(
    parameter int          NUM_CH     = 4,
    parameter int          CNT_W      = 32,
    parameter int          PRE_W      = 16,
    parameter int unsigned RST_PERIOD = 50_000_000 - 1
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic [$clog2(NUM_CH)+3-1:0]  address,
    input  logic                         chipselect,
    input  logic                         write_n,
    input  logic                         read_n,
    input  logic [31:0]                  writedata,
    output logic [31:0]                  readdata,
    output logic                         irq,
    output logic [NUM_CH-1:0]            irq_vec
);

    localparam int ADDR_W = $clog2(NUM_CH) + 3;
    localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic [CH_W-1:0] ch_sel;
    logic [2:0]      reg_sel;
    logic            wr_access;
    logic            rd_access;
    logic [31:0]     rd_vec [NUM_CH];
    logic [31:0]     rd_mux;

    assign reg_sel   = address[2:0];
    assign wr_access = chipselect && !write_n;
    assign rd_access = chipselect && !read_n;

    generate
        if (NUM_CH > 1) begin : g_ch_field
            assign ch_sel = address[ADDR_W-1:3];
        end else begin : g_single_ch
            assign ch_sel = 1'b0;
        end
    endgenerate

    // One channel per address window; unmatched channel codes decode to nothing
    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
            lab3_timer_channel #(
                .CNT_W      (CNT_W),
                .PRE_W      (PRE_W),
                .RST_PERIOD (RST_PERIOD)
            ) u_channel (
                .clk       (clk),
                .reset_n   (reset_n),
                .wr_en     (wr_access && (ch_sel == CH_W'(gi))),
                .reg_sel   (reg_sel),
                .writedata (writedata),
                .rd_data   (rd_vec[gi]),
                .irq       (irq_vec[gi])
            );
        end
    endgenerate

    // Select the addressed channel's read value; out-of-range channels read 0
    always_comb begin
        rd_mux = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (ch_sel == CH_W'(i)) begin
                rd_mux = rd_vec[i];
            end
        end
    end

    // Registered read data, held between reads
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            readdata <= '0;
        end else if (rd_access) begin
            readdata <= rd_mux;
        end
    end

    assign irq = |irq_vec;

endmodule

// File: tb/tb_lab3_multi_timer.sv
// Directed bench for lab3_multi_timer: a register-access vector table followed
// by hand-timed sequences for counting, timeouts, snapshots and reset.
`timescale 1ns/1ps
module tb_lab3_multi_timer;

    localparam int          NUM_CH = 4;
    localparam int          ADDR_W = $clog2(NUM_CH) + 3;
    localparam logic [31:0] RSTV   = 32'h02FA_F07F;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic [ADDR_W-1:0] address = '0;
    logic              chipselect = 1'b0;
    logic              write_n = 1'b1;
    logic              read_n = 1'b1;
    logic [31:0]       writedata = '0;
    logic [31:0]       readdata;
    logic              irq;
    logic [NUM_CH-1:0] irq_vec;

    int n_cmp  = 0;
    int n_fail = 0;
    int t      = 0;

    lab3_multi_timer #(
        .NUM_CH     (NUM_CH),
        .CNT_W      (32),
        .PRE_W      (16),
        .RST_PERIOD (50_000_000 - 1)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .read_n     (read_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .irq        (irq),
        .irq_vec    (irq_vec)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          is_wr;
        logic [4:0]  addr;
        logic [31:0] data;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs [17];

    task automatic step();
        @(posedge clk);
        #1;
        t++;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h want %h (t=%0d)", name, act, exp, t);
        end else begin
            $display("ok   %s: %h (t=%0d)", name, act, t);
        end
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0; read_n = 1'b1;
        step();
        chipselect = 1'b0; write_n = 1'b1;
    endtask

    task automatic rd(input logic [4:0] a, output logic [31:0] d);
        address = a; chipselect = 1'b1; read_n = 1'b0; write_n = 1'b1;
        step();
        chipselect = 1'b0; read_n = 1'b1;
        d = readdata;
    endtask

    function automatic logic [31:0] ch2_model(input int j);
        return 32'(3 - ((j / 5) % 4));
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d;
        int          t_snap;

        vecs[0]  = '{1'b0, 5'h02, 32'h0,         RSTV};
        vecs[1]  = '{1'b0, 5'h05, 32'h0,         RSTV};
        vecs[2]  = '{1'b0, 5'h00, 32'h0,         32'h0};
        vecs[3]  = '{1'b0, 5'h19, 32'h0,         32'h0};
        vecs[4]  = '{1'b0, 5'h14, 32'h0,         32'h0};
        vecs[5]  = '{1'b0, 5'h0B, 32'h0,         32'h0};
        vecs[6]  = '{1'b1, 5'h19, 32'hFFFF_FFF3, 32'h0};
        vecs[7]  = '{1'b0, 5'h19, 32'h0,         32'h3};
        vecs[8]  = '{1'b0, 5'h18, 32'h0,         32'h0};
        vecs[9]  = '{1'b1, 5'h1C, 32'hFFFF_1234, 32'h0};
        vecs[10] = '{1'b0, 5'h1C, 32'h0,         32'h1234};
        vecs[11] = '{1'b0, 5'h1E, 32'h0,         32'h0};
        vecs[12] = '{1'b1, 5'h1F, 32'hFFFF_FFFF, 32'h0};
        vecs[13] = '{1'b0, 5'h1F, 32'h0,         32'h0};
        vecs[14] = '{1'b1, 5'h19, 32'h0,         32'h0};
        vecs[15] = '{1'b0, 5'h19, 32'h0,         32'h0};
        vecs[16] = '{1'b0, 5'h1A, 32'h0,         RSTV};

        // Reset
        reset_n = 1'b0;
        step(); step(); step();
        reset_n = 1'b1;
        step();
        chk("reset_readdata", readdata, 32'h0);
        chk("reset_irq", 32'(irq), 32'h0);
        chk("reset_irq_vec", 32'(irq_vec), 32'h0);

        // Register access table
        for (int i = 0; i < 17; i++) begin
            if (vecs[i].is_wr) begin
                wr(vecs[i].addr, vecs[i].data);
            end else begin
                rd(vecs[i].addr, d);
                chk($sformatf("vec%0d_rd_%02h", i, vecs[i].addr), d, vecs[i].exp);
            end
        end

        // ch1 one-shot: START in the force-reload cycle must leave RUN clear
        wr(5'h0A, 32'd9);
        wr(5'h0C, 32'd0);
        wr(5'h09, 32'h5);
        rd(5'h08, d);
        chk("ch1_start_during_reload", d, 32'h0);
        wr(5'h09, 32'h5);
        t = 0;
        for (int k = 1; k <= 10; k++) begin
            step();
            chk($sformatf("ch1_irq_vec1_k%0d", k), 32'(irq_vec[1]), (k == 10) ? 32'h1 : 32'h0);
        end
        chk("ch1_irq", 32'(irq), 32'h1);
        rd(5'h08, d);
        chk("ch1_status_after_to", d, 32'h1);
        rd(5'h0D, d);
        chk("ch1_count_reloaded", d, 32'd9);
        wr(5'h08, 32'h0);
        chk("ch1_irq_cleared", 32'(irq), 32'h0);

        // ch2 continuous, prescale 4, period 3
        wr(5'h12, 32'd3);
        wr(5'h14, 32'd4);
        step();
        wr(5'h11, 32'h7);
        t = 0;
        address = 5'h15; chipselect = 1'b1; read_n = 1'b0;
        for (int k = 1; k <= 41; k++) begin
            step();
            chk($sformatf("ch2_count_k%0d", k), readdata, ch2_model(k - 1));
            chk($sformatf("ch2_to_k%0d", k), 32'(irq_vec[2]), (k >= 20) ? 32'h1 : 32'h0);
        end
        chipselect = 1'b0; read_n = 1'b1;
        wr(5'h10, 32'h0);
        chk("ch2_to_clr_t42", 32'(irq_vec[2]), 32'h0);
        while (t < 59) step();
        chk("ch2_to_t59", 32'(irq_vec[2]), 32'h0);
        step();
        chk("ch2_to_t60", 32'(irq_vec[2]), 32'h1);
        wr(5'h10, 32'h0);
        chk("ch2_to_clr_t61", 32'(irq_vec[2]), 32'h0);
        while (t < 79) step();
        wr(5'h10, 32'h0);
        chk("ch2_to_vs_status_wr_t80", 32'(irq_vec[2]), 32'h1);
        wr(5'h11, 32'hC);
        chk("ch2_ito_clr_drops_irq", 32'(irq_vec[2]), 32'h0);
        rd(5'h10, d);
        chk("ch2_status_stop_wins", d, 32'h1);
        rd(5'h05, d);
        chk("ch0_count_untouched", d, RSTV);
        rd(5'h1D, d);
        chk("ch3_count_untouched", d, RSTV);

        // ch0 running: snapshot then force-reload via PERIOD write
        wr(5'h01, 32'h4);
        t = 0;
        step(); step(); step(); step(); step();
        wr(5'h03, 32'h0);
        t_snap = t;
        rd(5'h05, d);
        chk("ch0_count_running", d, RSTV - 32'(t - 1));
        rd(5'h03, d);
        chk("ch0_snap", d, RSTV - 32'(t_snap - 1));
        wr(5'h02, 32'h55);
        step();
        rd(5'h05, d);
        chk("ch0_count_new_period", d, 32'h55);
        rd(5'h00, d);
        chk("ch0_status_run_cleared", d, 32'h0);

        // Reset asserted mid-count
        wr(5'h09, 32'h7);
        for (int k = 0; k < 10; k++) step();
        rd(5'h0A, d);
        chk("pre_reset_readdata", d, 32'd9);
        chk("pre_reset_irq", 32'(irq), 32'h1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("async_reset_readdata", readdata, 32'h0);
        chk("async_reset_irq", 32'(irq), 32'h0);
        chk("async_reset_irq_vec", 32'(irq_vec), 32'h0);
        step(); step();
        reset_n = 1'b1;
        step();
        rd(5'h0D, d);
        chk("post_reset_ch1_count", d, RSTV);
        rd(5'h08, d);
        chk("post_reset_ch1_status", d, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
